disp_share_arbiter: RTL and testbench

- Time-slices the single 4-digit seven-segment display multiplexer among NUM_REQ independent requesters.
- Each requester presents a 16-bit hex value (four nibbles, digit 0 in bits [3:0]) and a request line.
- The arbiter grants ownership round-robin, holds each owner for a minimum dwell period, and drives the winning value onto the 16-bit input of the display multiplexer.
- Sits between the application logic and the display driver; the driver is unchanged.

---
 rtl/disp_share_arbiter_pkg.sv | 12 +
 rtl/disp_share_arbiter_rr_picker.sv | 32 +++
 rtl/disp_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_disp_share_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/disp_share_arbiter_pkg.sv
// Shared definitions for the display-sharing arbiter: FSM encoding and display widths.
package disp_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned DISP_W  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

endpackage

// File: rtl/disp_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping,
// optionally skipping one excluded index.
module rr_picker #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    input  logic                 excl_en,
    input  logic [$clog2(N)-1:0] excl_idx,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] w_cand;

    // Scan from farthest to nearest so the nearest candidate after 'last' wins.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int unsigned k = N; k >= 1; k--) begin
            w_cand = IW'((32'(last) + k) % N);
            if (req[w_cand] && !(excl_en && (w_cand == excl_idx))) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/disp_share_arbiter.sv
// Round-robin time-slicing of one 4-digit seven-segment display among NUM_REQ requesters,
// with a minimum dwell per grant, a lock to freeze ownership and a done pulse per completed dwell.
module disp_share_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DWELL   = 5000000,
    parameter int unsigned CNT_W   = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [DISP_W*NUM_REQ-1:0] data_flat,
    input  logic                      lock,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DISP_W-1:0]         disp_data,
    output logic                      disp_valid,
    output logic [NUM_REQ-1:0]        done
);

    localparam int unsigned OW = $clog2(NUM_REQ);

    state_t               r_state;
    logic [OW-1:0]        r_owner;
    logic [OW-1:0]        r_last;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_valid;
    logic [DISP_W-1:0]    r_disp_data;

    logic                 w_expire;
    logic                 w_own_req;
    logic [OW-1:0]        w_pick_last;
    logic                 w_excl_en;
    logic                 w_any;
    logic [OW-1:0]        w_pick;
    logic                 w_nxt_show;
    logic [OW-1:0]        w_nxt_owner;
    logic                 w_cnt_clr;
    logic                 w_cnt_inc;
    logic                 w_done_set;
    logic [DISP_W-1:0]    w_nxt_data;

    assign w_own_req   = req[r_owner];
    assign w_expire    = (r_state == ST_SHOW) && !lock && (r_cnt == CNT_W'(DWELL - 1));
    // On expiry the rotation restarts after the owner; on an early drop the owner is skipped.
    assign w_pick_last = w_expire ? r_owner : r_last;
    assign w_excl_en   = (r_state == ST_SHOW) && !w_expire;

    rr_picker #(
        .N (NUM_REQ)
    ) u_picker (
        .req      (req),
        .last     (w_pick_last),
        .excl_en  (w_excl_en),
        .excl_idx (r_owner),
        .any      (w_any),
        .idx      (w_pick)
    );

    // Next owner / counter control.
    always_comb begin
        w_nxt_show  = 1'b0;
        w_nxt_owner = r_owner;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_nxt_show  = 1'b1;
                    w_nxt_owner = w_pick;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_SHOW: begin
                if (lock) begin
                    w_nxt_show = 1'b1;
                end else if (w_expire || !w_own_req) begin
                    if (w_any) begin
                        w_nxt_show  = 1'b1;
                        w_nxt_owner = w_pick;
                        w_cnt_clr   = 1'b1;
                    end
                end else begin
                    w_nxt_show = 1'b1;
                    w_cnt_inc  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // done is registered so it is visible during the final cycle of the dwell.
    assign w_done_set = (r_state == ST_SHOW) && !lock && w_own_req &&
                        (r_cnt == CNT_W'(DWELL - 2));

    always_comb begin
        w_nxt_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_nxt_owner == OW'(i)) begin
                w_nxt_data = data_flat[i*DISP_W +: DISP_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_last      <= OW'(NUM_REQ - 1);
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_valid     <= 1'b0;
            r_disp_data <= '0;
        end else begin
            r_state <= w_nxt_show ? ST_SHOW : ST_IDLE;
            r_owner <= w_nxt_owner;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_expire) begin
                r_last <= r_owner;
            end
            r_gnt   <= w_nxt_show ? (NUM_REQ'(1) << w_nxt_owner) : '0;
            r_valid <= w_nxt_show;
            r_done  <= w_done_set ? (NUM_REQ'(1) << r_owner) : '0;
            if (w_nxt_show) begin
                r_disp_data <= w_nxt_data;
            end
        end
    end

    assign gnt        = r_gnt;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_valid;
    assign done       = r_done;

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Self-checking bench for disp_share_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level ownership model.
module tb_disp_share_arbiter;

    localparam int N     = 4;
    localparam int DWELL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [16*N-1:0] data_flat;
    logic          lock;
    logic [N-1:0]  gnt;
    logic [15:0]   disp_data;
    logic          disp_valid;
    logic [N-1:0]  done;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: who owns the display, how many cycles of the dwell they have shown, last finisher.
    bit          m_owned;
    int          m_owner;
    int          m_age;
    int          m_last;
    logic [15:0] m_data;
    logic [N-1:0] m_done;

    always #5 clk = ~clk;

    disp_share_arbiter #(
        .NUM_REQ (N),
        .DWELL   (DWELL),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_flat  (data_flat),
        .lock       (lock),
        .gnt        (gnt),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic logic [15:0] slc(input int i);
        return data_flat[16*i +: 16];
    endfunction

    // First requester after 'from', wrapping, skipping 'excl'; -1 if none.
    function automatic int rr(input int from, input logic [N-1:0] r, input int excl);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (from + k) % N;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic grant_or_idle(input int p);
        if (p >= 0) begin
            m_owner = p;
            m_age   = 1;
            m_data  = slc(p);
        end else begin
            m_owned = 1'b0;
        end
    endtask

    task automatic model_edge();
        int p;
        m_done = '0;
        if (rst) begin
            m_owned = 1'b0;
            m_age   = 0;
            m_last  = N - 1;
            m_data  = '0;
        end else if (!m_owned) begin
            p = rr(m_last, req, -1);
            if (p >= 0) begin
                m_owned = 1'b1;
                grant_or_idle(p);
            end
        end else if (lock) begin
            m_data = slc(m_owner);
        end else if (m_age == DWELL) begin
            m_last = m_owner;
            grant_or_idle(rr(m_owner, req, -1));
        end else if (!req[m_owner]) begin
            grant_or_idle(rr(m_last, req, m_owner));
        end else begin
            m_age++;
            m_data = slc(m_owner);
            if (m_age == DWELL) m_done[m_owner] = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("gnt",        32'(gnt),        m_owned ? 32'(1 << m_owner) : 32'd0);
        check("disp_valid", 32'(disp_valid), 32'(m_owned));
        check("disp_data",  32'(disp_data),  32'(m_data));
        check("done",       32'(done),       32'(m_done));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = 1'b0; data_flat = '0;
        m_owned = 0; m_owner = 0; m_age = 0; m_last = N - 1; m_data = '0; m_done = '0;
        step();
        step();
        rst = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 10; i++) step();

        // Two requesters alternate, requester 0 first.
        data_flat[15:0]  = 16'h1234;
        data_flat[47:32] = 16'hBEEF;
        req = 4'b0101;
        step();
        check("dir_first_gnt",  32'(gnt), 32'h1);
        check("dir_first_data", 32'(disp_data), 32'h1234);
        step(); step(); step();
        check("dir_done0", 32'(done), 32'h1);
        step();
        check("dir_second_gnt",  32'(gnt), 32'h4);
        check("dir_second_data", 32'(disp_data), 32'hBEEF);
        step(); step(); step();
        check("dir_done2", 32'(done), 32'h4);
        step();
        check("dir_back_to_0", 32'(gnt), 32'h1);

        // Lock freezes the owner while another request waits.
        req = 4'b0011;
        step();
        lock = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("dir_lock_hold", 32'(gnt), 32'h1);
        lock = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 5) == 0) lock = ~lock;
            if ($urandom_range(0, 3) == 0) data_flat = {$urandom, $urandom};
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        // Reset mid-dwell, then all request: requester 0 wins first.
        rst = 1'b0; lock = 1'b0; req = 4'b0100;
        step(); step();
        rst = 1'b1;
        step();
        check("dir_rst_gnt",   32'(gnt), 32'h0);
        check("dir_rst_valid", 32'(disp_valid), 32'h0);
        check("dir_rst_data",  32'(disp_data), 32'h0);
        rst = 1'b0; req = 4'b1111;
        step();
        check("dir_post_rst_gnt", 32'(gnt), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
